// File: rtl/rk4_uart_pkg.sv
// Shared UART link definitions for the RK4 result transmitter.
package rk4_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam logic        UART_IDLE_LEVEL      = 1'b1;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer; accepts the next byte in the last stop-bit cycle so
// consecutive frames chain with no gap.
module uart_tx_byte
  import rk4_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [UART_DATA_BITS-1:0] byte_data_i,
  input  logic                      byte_valid_i,
  output logic                      byte_ready_o,
  output logic                      tx_o
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BitLast  = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state_q;
  logic [CntW-1:0]           baud_q;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      tx_q;
  logic                      baud_done;

  assign baud_done    = (baud_q == BaudLast);
  assign byte_ready_o = (state_q == IDLE) || ((state_q == STOP) && baud_done);
  assign tx_o         = tx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (byte_valid_i) begin
            shift_q <= byte_data_i;
            bit_q   <= '0;
            tx_q    <= ~UART_IDLE_LEVEL;
            state_q <= START;
          end else begin
            tx_q <= UART_IDLE_LEVEL;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == BitLast) begin
              bit_q   <= '0;
              tx_q    <= UART_IDLE_LEVEL;
              state_q <= STOP;
            end else begin
              // Next bit is presented from shift_q[1] on the same edge the shift happens.
              bit_q   <= bit_q + 1'b1;
              shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (byte_valid_i) begin
              shift_q <= byte_data_i;
              tx_q    <= ~UART_IDLE_LEVEL;
              state_q <= START;
            end else begin
              tx_q    <= UART_IDLE_LEVEL;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= UART_IDLE_LEVEL;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/rk4_result_tx.sv
// Sends each accepted RK4 result word as WORD_BYTES back-to-back 8N1 frames,
// most-significant byte first.
module rk4_result_tx
  import rk4_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned WORD_BYTES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORD_BYTES-1:0] word_data,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    uart_tx,
  output logic                    busy
);

  localparam int unsigned     WordW   = UART_DATA_BITS * WORD_BYTES;
  localparam int unsigned     IdxW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(WORD_BYTES - 1);

  logic [WordW-1:0]          word_q;
  logic [IdxW-1:0]           idx_q;
  logic                      busy_q;
  logic                      ready_q;

  logic                      accept;
  logic                      more_bytes;
  logic                      byte_valid;
  logic                      byte_ready;
  logic [IdxW-1:0]           next_sel;
  logic [UART_DATA_BITS-1:0] byte_data;

  assign accept     = ready_q && word_valid;
  assign more_bytes = busy_q && (idx_q != IdxLast);

  // The first byte comes straight from word_data so the start bit begins on the
  // handshake edge; later bytes come from the latched word.
  always_comb begin
    next_sel   = '0;
    if (more_bytes) begin
      next_sel = IdxLast - idx_q - 1'b1;
    end
    byte_valid = accept || more_bytes;
    if (accept) begin
      byte_data = word_data[WordW-1 -: UART_DATA_BITS];
    end else begin
      byte_data = word_q[UART_DATA_BITS * next_sel +: UART_DATA_BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else if (accept) begin
      word_q  <= word_data;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
    end else if (busy_q && byte_ready) begin
      // byte_ready while busy marks the final cycle of a stop bit.
      if (more_bytes) begin
        idx_q <= idx_q + 1'b1;
      end else begin
        busy_q  <= 1'b0;
        ready_q <= 1'b1;
      end
    end else if (!busy_q) begin
      ready_q <= 1'b1;
    end
  end

  assign word_ready = ready_q;
  assign busy       = busy_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i       (clk),
    .rst_i       (rst),
    .byte_data_i (byte_data),
    .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready),
    .tx_o        (uart_tx)
  );

endmodule

// File: tb/tb_rk4_result_tx.sv
// Directed + randomized bench: a line decoder rebuilds bytes from uart_tx and a
// word-to-byte model supplies the expected stream and frame timing.
module tb_rk4_result_tx;

  localparam int unsigned FCPB = 4;
  localparam int unsigned SCPB = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] wd_f, wd_s;
  logic        wv_f, wv_s, wr_f, wr_s, tx_f, tx_s, busy_f, busy_s;

  rk4_result_tx #(.CLKS_PER_BIT(FCPB), .WORD_BYTES(4)) dut (
    .clk(clk), .rst(rst), .word_data(wd_f), .word_valid(wv_f),
    .word_ready(wr_f), .uart_tx(tx_f), .busy(busy_f)
  );

  rk4_result_tx #(.CLKS_PER_BIT(SCPB), .WORD_BYTES(4)) dut_slow (
    .clk(clk), .rst(rst), .word_data(wd_s), .word_valid(wv_s),
    .word_ready(wr_s), .uart_tx(tx_s), .busy(busy_s)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Line decoder for the fast instance; frames interrupted by reset are dropped.
  logic [7:0] rx_q[$];
  logic       rxs_q[$];
  int         rxc_q[$];
  logic [7:0] m_b;
  logic       m_stop, m_ok;
  int         m_c;

  always begin
    @(negedge clk);
    if (rst === 1'b0 && tx_f === 1'b0) begin
      m_c = cyc; m_ok = 1'b1; m_b = '0; m_stop = 1'b0;
      for (int i = 0; i < 9; i++) begin
        for (int j = 0; j < FCPB; j++) begin
          @(negedge clk);
          if (rst !== 1'b0) m_ok = 1'b0;
        end
        if (i < 8) m_b[i] = tx_f;
        else m_stop = tx_f;
      end
      if (m_ok) begin
        rx_q.push_back(m_b);
        rxs_q.push_back(m_stop);
        rxc_q.push_back(m_c);
      end
    end
  end

  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) exp_q.push_back(8'(w >> (8 * k)));
  endtask

  task automatic check_stream(input string tag);
    int n;
    chk({tag, " byte count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s byte%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
      chk($sformatf("%s stop%0d", tag, i), 64'(rxs_q[i]), 64'd1);
    end
    rx_q.delete(); rxs_q.delete(); rxc_q.delete(); exp_q.delete();
  endtask

  // Called on a falling edge; returns the cycle number of the handshake edge.
  task automatic send_word(input logic [31:0] d, input bit hold, output int hs);
    int n;
    wd_f = d; wv_f = 1'b1; n = 0;
    while (wr_f !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("handshake wait in budget", 64'(n < 1000), 64'd1);
    @(posedge clk);
    #1 hs = cyc;
    @(negedge clk);
    if (!hold) wv_f = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(busy_f === 1'b0 && wr_f === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle wait in budget", 64'(n < 2000), 64'd1);
  endtask

  int          hs, hs1, hs2, n, nb;
  logic [31:0] w;
  logic        bits[40];
  int          exp_tr[$], obs_tr[$];
  logic        prev;
  logic [7:0]  sb;

  initial begin
    rst = 1'b1; wd_f = '0; wv_f = 1'b0; wd_s = '0; wv_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx", 64'(tx_f), 64'd1);
    chk("reset ready", 64'(wr_f), 64'd0);
    chk("reset busy", 64'(busy_f), 64'd0);
    chk("reset tx slow", 64'(tx_s), 64'd1);
    rst = 1'b0;
    #1 chk("ready before first edge", 64'(wr_f), 64'd0);
    @(negedge clk);
    chk("ready after release", 64'(wr_f), 64'd1);
    chk("busy after release", 64'(busy_f), 64'd0);

    // Single word, busy width and ready return
    send_word(32'hDEADBEEF, 1'b0, hs);
    expect_word(32'hDEADBEEF);
    chk("start bit on handshake edge", 64'(tx_f), 64'd0);
    chk("ready drops on handshake edge", 64'(wr_f), 64'd0);
    n = 0;
    while (busy_f === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("busy cycles", 64'(n), 64'd160);
    chk("ready returns with busy fall", 64'(wr_f), 64'd1);
    repeat (5) @(negedge clk);
    chk("first frame start cycle", 64'(rxc_q.size() > 0 ? rxc_q[0] : -1), 64'(hs));
    chk("last frame start cycle", 64'(rxc_q.size() > 3 ? rxc_q[3] : -1), 64'(hs + 120));
    check_stream("single");

    // Back-to-back with valid held high
    send_word(32'h00000001, 1'b1, hs1);
    expect_word(32'h00000001);
    send_word(32'hFFFFFFFF, 1'b0, hs2);
    expect_word(32'hFFFFFFFF);
    chk("b2b handshake spacing", 64'(hs2 - hs1), 64'd161);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("b2b start gap", 64'(rxc_q.size() > 4 ? rxc_q[4] - rxc_q[3] : -1), 64'd41);
    check_stream("b2b");

    // Stall: data churns while busy, only the accepted word goes out
    w = $urandom;
    send_word(w, 1'b1, hs);
    expect_word(w);
    repeat (150) begin
      wd_f = $urandom;
      @(negedge clk);
    end
    wv_f = 1'b0;
    wait_idle();
    repeat (60) @(negedge clk);
    check_stream("stall");

    // Random words
    for (int r = 0; r < 3; r++) begin
      w = $urandom;
      send_word(w, 1'b0, hs);
      expect_word(w);
      wait_idle();
    end
    repeat (5) @(negedge clk);
    check_stream("random");

    // Reset during bit 3 of byte 2 of 0x12345678
    send_word(32'h12345678, 1'b0, hs);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    repeat (97) @(negedge clk);
    chk("mid-frame bit3 level", 64'(tx_f), 64'd0);
    rst = 1'b1;
    #1;
    chk("reset forces tx high", 64'(tx_f), 64'd1);
    chk("reset clears busy", 64'(busy_f), 64'd0);
    chk("reset clears ready", 64'(wr_f), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check_stream("pre-reset");
    chk("ready after mid-word reset", 64'(wr_f), 64'd1);
    send_word(32'hA5A5A5A5, 1'b0, hs);
    expect_word(32'hA5A5A5A5);
    wait_idle();
    repeat (5) @(negedge clk);
    check_stream("post-reset");

    // Slow instance: exact line transition times from the bit-level model
    w = 32'h55AA00FF;
    for (int b = 0; b < 4; b++) begin
      sb = 8'(w >> (8 * (3 - b)));
      bits[10 * b] = 1'b0;
      for (int i = 0; i < 8; i++) bits[10 * b + 1 + i] = sb[i];
      bits[10 * b + 9] = 1'b1;
    end
    wd_s = w; wv_s = 1'b1; n = 0;
    while (wr_s !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("slow handshake wait in budget", 64'(n < 1000), 64'd1);
    @(posedge clk);
    #1 hs = cyc;
    @(negedge clk);
    wv_s = 1'b0;
    prev = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bits[k] != prev) exp_tr.push_back(hs + k * SCPB);
      prev = bits[k];
    end
    prev = 1'b1; nb = 0;
    for (int k = 0; k < 40 * SCPB + 20; k++) begin
      if (tx_s !== prev) begin
        obs_tr.push_back(cyc);
        prev = tx_s;
      end
      if (busy_s === 1'b1) nb++;
      @(negedge clk);
    end
    chk("slow busy cycles", 64'(nb), 64'(40 * SCPB));
    chk("slow transition count", 64'(obs_tr.size()), 64'(exp_tr.size()));
    for (int i = 0; i < exp_tr.size() && i < obs_tr.size(); i++)
      chk($sformatf("slow edge%0d cycle", i), 64'(obs_tr[i]), 64'(exp_tr[i]));
    chk("slow line idle after word", 64'(tx_s), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
